fifo_rr_arbiter: RTL and testbench
==================================

# fifo_rr_arbiter

Round-robin write arbiter that shares one synchronous FIFO write port between NUM_REQ producers. It grants one producer at a time for a bounded burst, passes that producer's data straight to the FIFO write port, and back-pressures using the FIFO's `full` flag. It sits directly in front of the team's sync FIFO and drives its `wr_en`/`din`.

## Interface
- `NUM_REQ`, 4: number of producers; legal range 2..16.
- `DATA_WIDTH`, 8: data width; must match the FIFO.
- `BURST_LEN`, 4: maximum beats accepted per grant; must be ≥1.
- `clk`  in  1  single clock; all logic on the rising edge.
- `sclr`  in  1  reset, synchronous, active-high.
- `req_valid`  in  NUM_REQ  per-producer data valid.
- `req_data`  in  NUM_REQ*DATA_WIDTH  producer i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ready`  out  NUM_REQ  per-producer accept; one-hot or zero.
- `fifo_full`  in  1  FIFO `full` flag.
- `fifo_wr_en`  out  1  FIFO write enable.
- `fifo_din`  out  DATA_WIDTH  FIFO write data.
- `grant_id`  out  $clog2(NUM_REQ)  index of the current/last granted producer.
- `busy`  out  1  high while in GRANT.
- `stall_cnt`  out  16  blocked-cycle counter (see Configuration).

## Operation
- FSM, two states: IDLE and GRANT. Registered: `state`, `grant_id`, `rr_ptr` (next-priority index), `beat_cnt` ($clog2(BURST_LEN+1) bits).
- IDLE: if any `req_valid`, search indices rr_ptr, rr_ptr+1, … mod NUM_REQ. Latch the first valid index into `grant_id`, clear `beat_cnt`, go to GRANT. Otherwise stay in IDLE. No beats are accepted in IDLE.
- GRANT: `accept = req_valid[grant_id] & ~fifo_full`. `req_ready[grant_id] = ~fifo_full`. All other `req_ready` are 0.
- Write path: `fifo_wr_en = accept`. `fifo_din = req_data` slice `grant_id`. This path is combinational, with zero added latency.
- Each accepted beat increments `beat_cnt`.
- Release from GRANT to IDLE in either case:
  - (a) accept occurs with `beat_cnt == BURST_LEN-1` (last beat);
  - (b) `req_valid[grant_id] == 0` in any GRANT cycle (producer yields; nothing written that cycle).
- On release, `rr_ptr <= (grant_id == NUM_REQ-1) ? 0 : grant_id+1`, so the pointer wraps.
- Full stall: while `fifo_full` is high in GRANT, no accept occurs. The grant is held and `beat_cnt` does not advance; stalling never causes a release.
- Outside GRANT, `req_ready`, `fifo_wr_en` and `fifo_din` are all 0.
- Reset values: `state` IDLE, `rr_ptr` 0, `grant_id` 0, `beat_cnt` 0, `busy` 0, `stall_cnt` 0. `req_ready`, `fifo_wr_en` and `fifo_din` are 0.
- While `sclr` is high, `req_ready` and `fifo_wr_en` are forced to 0 combinationally, including mid-burst. The beat presented in that cycle is not written.

## Timing
- Grant latency: `req_valid` first sampled high in IDLE at edge N puts the block in GRANT after edge N. The earliest write is the cycle after edge N.
- Throughput: up to BURST_LEN back-to-back beats per grant. Exactly one IDLE cycle separates consecutive grants.
- Fairness: with all producers continuously valid and the FIFO never full, grants cycle 0,1,…,NUM_REQ-1,0. Each grant writes BURST_LEN beats.
- `fifo_full` is used the same cycle; the FIFO's registered flag already reflects prior writes. No write is issued while full, so the FIFO `overflow` flag never asserts from this block.
- `busy` equals (`state == GRANT`).
- `grant_id` holds its last value in IDLE.

## Configuration
- `FIFO_ARB_STALL_CNT_EN` defined:
  - `stall_cnt` increments on each GRANT cycle with `req_valid[grant_id] & fifo_full`.
  - It saturates at 16'hFFFF and clears only on `sclr`.
- Not defined: `stall_cnt` is tied to 16'h0000 and no counter register exists.

## Test plan
- Reset: hold `sclr` 3 cycles with all `req_valid`=1. Required: `fifo_wr_en`=0 throughout, and the first grant after release is `grant_id`=0.
- Fairness: all 4 producers valid, FIFO never full, BURST_LEN=4. Required:
  - grants in order 0,1,2,3,0;
  - 4 writes per grant with 1 idle cycle between grants;
  - `fifo_din` matches the granted producer's data.
- Early yield: producer 2 alone drops valid after 2 beats. Required: release after 2 writes, and `rr_ptr`=3 so the next search starts at producer 3.
- Full stall: `fifo_full`=1 for 5 cycles mid-burst after beat 1. Required:
  - `fifo_wr_en`=0 for those 5 cycles;
  - grant held, then beats 2–4 complete;
  - `stall_cnt`=5 with `FIFO_ARB_STALL_CNT_EN` defined, 0 without.
- Wrap: only producer 3 valid, then only producer 0. Required: grant 3, then grant 0 with the pointer wrapping to 0.
- Reset mid-burst: assert `sclr` during beat 2 of a grant. Required:
  - that beat is not written;
  - `busy`=0 after the edge;
  - `stall_cnt` and `rr_ptr` are 0.

Source files
------------

// File: rtl/fifo_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rr_arbiter
// Purpose  : Round-robin burst arbiter sharing one sync FIFO write port.
//            Define FIFO_ARB_STALL_CNT_EN to build the full-stall counter.
// Revision : 1.0
// ============================================================================
module fifo_rr_arbiter #(
  parameter int  NUM_REQ    = 4,
  parameter int  DATA_WIDTH = 8,
  parameter int  BURST_LEN  = 4,
  localparam int c_ID_W     = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          sclr,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  output logic [c_ID_W-1:0]             grant_id,
  output logic                          busy,
  output logic [15:0]                   stall_cnt
);

  localparam int c_BC_W = $clog2(BURST_LEN + 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [c_ID_W-1:0]   r_grant_id, w_grant_id_nxt;
  logic [c_ID_W-1:0]   r_rr_ptr, w_rr_ptr_nxt, w_ptr_inc;
  logic [c_BC_W-1:0]   r_beat_cnt, w_beat_cnt_nxt;
  logic [c_ID_W-1:0]   w_pick_hi, w_pick_lo, w_pick;
  logic                w_found_hi, w_found;
  logic                w_in_grant, w_sel_valid, w_accept, w_last_beat;
  logic [DATA_WIDTH-1:0] w_sel_data;

  // First valid index at or above rr_ptr wins; otherwise wrap to lowest valid.
  always_comb begin
    w_pick_hi  = '0;
    w_pick_lo  = '0;
    w_found_hi = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        w_pick_lo = c_ID_W'(i);
        if (c_ID_W'(i) >= r_rr_ptr) begin
          w_pick_hi  = c_ID_W'(i);
          w_found_hi = 1'b1;
        end
      end
    end
    w_found = |req_valid;
    w_pick  = w_found_hi ? w_pick_hi : w_pick_lo;
  end

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant_id == c_ID_W'(i)) begin
        w_sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_in_grant  = (r_state == ST_GRANT);
  assign w_sel_valid = req_valid[r_grant_id];
  assign w_accept    = w_in_grant & w_sel_valid & ~fifo_full & ~sclr;
  assign w_last_beat = (r_beat_cnt == c_BC_W'(BURST_LEN - 1));
  assign w_ptr_inc   = (r_grant_id == c_ID_W'(NUM_REQ - 1)) ? '0 : r_grant_id + c_ID_W'(1);

  always_comb begin
    w_state_nxt    = r_state;
    w_grant_id_nxt = r_grant_id;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_beat_cnt_nxt = r_beat_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt    = ST_GRANT;
          w_grant_id_nxt = w_pick;
          w_beat_cnt_nxt = '0;
        end
      end
      ST_GRANT: begin
        // A full FIFO only holds the grant; release comes from yield or last beat.
        if (!w_sel_valid || (w_accept && w_last_beat)) begin
          w_state_nxt  = ST_IDLE;
          w_rr_ptr_nxt = w_ptr_inc;
        end else if (w_accept) begin
          w_beat_cnt_nxt = r_beat_cnt + c_BC_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      r_state    <= ST_IDLE;
      r_grant_id <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant_id <= w_grant_id_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = w_in_grant & ~fifo_full & ~sclr & (r_grant_id == c_ID_W'(i));
    end
  end

  assign fifo_wr_en = w_accept;
  assign fifo_din   = w_in_grant ? w_sel_data : '0;
  assign grant_id   = r_grant_id;
  assign busy       = w_in_grant;

`ifdef FIFO_ARB_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (sclr) begin
      r_stall_cnt <= '0;
    end else if (w_in_grant && w_sel_valid && fifo_full && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_rr_arbiter
// Purpose  : Directed scenarios plus random traffic against a burst-level model.
// Revision : 1.0
// ============================================================================
module tb_fifo_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int BL = 4;

  logic            clk       = 1'b0;
  logic            sclr      = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data  = '0;
  logic            fifo_full = 1'b0;
  logic [N-1:0]    req_ready;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_din;
  logic [1:0]      grant_id;
  logic            busy;
  logic [15:0]     stall_cnt;

  always #5 clk = ~clk;

  fifo_rr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk        (clk),
    .sclr       (sclr),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .grant_id   (grant_id),
    .busy       (busy),
    .stall_cnt  (stall_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit run      = 1'b0;

  // Model: who holds the grant, beats written so far, next-priority index.
  bit m_busy  = 1'b0;
  int m_gid   = 0;
  int m_ptr   = 0;
  int m_beats = 0;
  int m_stall = 0;

  int   dut_grants[$];
  int   dut_writes[$];
  logic prev_busy = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_stall(input int modeled);
`ifdef FIFO_ARB_STALL_CNT_EN
    return modeled;
`else
    return 0 * modeled;
`endif
  endfunction

  always @(negedge clk) begin
    logic [N-1:0]  e_ready;
    logic          e_wr;
    logic [DW-1:0] e_din;
    if (run) begin
      e_wr    = m_busy && req_valid[m_gid] && !fifo_full && !sclr;
      e_ready = '0;
      if (m_busy && !fifo_full && !sclr) e_ready[m_gid] = 1'b1;
      e_din   = m_busy ? req_data[m_gid*DW +: DW] : '0;

      chk("fifo_wr_en", fifo_wr_en, e_wr);
      chk("req_ready", req_ready, e_ready);
      chk("busy", busy, m_busy);
      chk("grant_id", grant_id, m_gid);
      if (!sclr) chk("fifo_din", fifo_din, e_din);
      chk("stall_cnt", stall_cnt, exp_stall(m_stall));

      if (busy && !prev_busy) begin
        dut_grants.push_back(int'(grant_id));
        dut_writes.push_back(0);
      end
      if (fifo_wr_en && dut_writes.size() > 0) dut_writes[dut_writes.size()-1]++;
      prev_busy = busy;

      // Advance the model to what the coming rising edge must produce.
      if (sclr) begin
        m_busy = 1'b0; m_gid = 0; m_ptr = 0; m_beats = 0; m_stall = 0;
      end else if (!m_busy) begin
        for (int k = 0; k < N; k++) begin
          if (req_valid[(m_ptr + k) % N]) begin
            m_gid = (m_ptr + k) % N; m_busy = 1'b1; m_beats = 0;
            break;
          end
        end
      end else begin
        if (req_valid[m_gid] && fifo_full && m_stall < 65535) m_stall++;
        if (!req_valid[m_gid]) begin
          m_busy = 1'b0; m_ptr = (m_gid + 1) % N;
        end else if (!fifo_full) begin
          m_beats++;
          if (m_beats == BL) begin
            m_busy = 1'b0; m_ptr = (m_gid + 1) % N;
          end
        end
      end
    end
  end

  task automatic drive(input logic [N-1:0] v, input bit full, input bit rst, input int cycles);
    repeat (cycles) begin
      @(posedge clk); #1;
      req_valid = v;
      fifo_full = full;
      sclr      = rst;
      for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'($urandom);
    end
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic clear_log();
    dut_grants.delete();
    dut_writes.delete();
  endtask

  task automatic chk_grant(input string name, input int idx, input int exp_id, input int exp_wr);
    chk({name, "_present"}, dut_grants.size() > idx, 1);
    if (dut_grants.size() > idx) begin
      chk({name, "_id"}, dut_grants[idx], exp_id);
      if (exp_wr >= 0) chk({name, "_writes"}, dut_writes[idx], exp_wr);
    end
  endtask

  initial begin
    @(posedge clk);
    run = 1'b1;

    // Reset held with everyone valid, then fairness over five grants.
    drive(4'hF, 1'b0, 1'b1, 3);
    clear_log();
    drive(4'hF, 1'b0, 1'b0, 25);
    settle();
    chk("fair_ngrants", dut_grants.size(), 5);
    chk_grant("fair_g0", 0, 0, 4);
    chk_grant("fair_g1", 1, 1, 4);
    chk_grant("fair_g2", 2, 2, 4);
    chk_grant("fair_g3", 3, 3, 4);
    chk_grant("fair_g4", 4, 0, 4);

    // Producer 2 yields after two beats; search then starts at producer 3.
    drive(4'h0, 1'b0, 1'b1, 1);
    clear_log();
    drive(4'b0100, 1'b0, 1'b0, 3);
    drive(4'b0000, 1'b0, 1'b0, 1);
    drive(4'b1001, 1'b0, 1'b0, 3);
    settle();
    chk_grant("yield_g0", 0, 2, 2);
    chk_grant("yield_g1", 1, 3, -1);

    // Five full cycles after beat 1.
    drive(4'h0, 1'b0, 1'b1, 1);
    clear_log();
    drive(4'hF, 1'b0, 1'b0, 2);
    drive(4'hF, 1'b1, 1'b0, 5);
    drive(4'hF, 1'b0, 1'b0, 3);
    settle();
    chk_grant("stall_g0", 0, 0, 4);
    chk("stall_ngrants", dut_grants.size(), 1);
`ifdef FIFO_ARB_STALL_CNT_EN
    chk("stall_cnt_lit", stall_cnt, 5);
`else
    chk("stall_cnt_lit", stall_cnt, 0);
`endif

    // Pointer wrap from producer 3 to producer 0.
    drive(4'h0, 1'b0, 1'b1, 1);
    clear_log();
    drive(4'b1000, 1'b0, 1'b0, 5);
    drive(4'b0001, 1'b0, 1'b0, 5);
    settle();
    chk_grant("wrap_g0", 0, 3, 4);
    chk_grant("wrap_g1", 1, 0, 4);

    // Reset during beat 2 of producer 1's burst, after some stall cycles.
    clear_log();
    drive(4'hF, 1'b0, 1'b0, 2);
    drive(4'hF, 1'b1, 1'b0, 2);
    drive(4'hF, 1'b0, 1'b1, 1);
    settle();
    chk("midrst_wr_en", fifo_wr_en, 0);
    chk("midrst_busy_before", busy, 1);
    drive(4'hF, 1'b0, 1'b0, 1);
    settle();
    chk("midrst_busy_after", busy, 0);
    chk("midrst_stall_after", stall_cnt, 0);
    drive(4'hF, 1'b0, 1'b0, 1);
    settle();
    chk_grant("midrst_g0", 0, 1, 1);
    chk_grant("midrst_g1", 1, 0, -1);

    // Random traffic with back-pressure and occasional resets.
    for (int c = 0; c < 600; c++) begin
      logic [N-1:0] v;
      for (int i = 0; i < N; i++) v[i] = ($urandom_range(0, 9) < 8);
      drive(v, ($urandom_range(0, 9) < 3), ($urandom_range(0, 99) == 0), 1);
    end
    drive(4'h0, 1'b0, 1'b0, 2);
    settle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
